// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared byte type for the cipher output path
package cipher_pkg;

  localparam int CIPHER_BYTE_W = 9;

  typedef struct packed {
    logic       encrypt;
    logic [7:0] data;
  } cipher_byte_t;

endpackage

// File: rtl/cipher_fifo_mem.sv
// rtl/cipher_fifo_mem.sv - simple dual-port storage, sync write, async read
module cipher_fifo_mem
  import cipher_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  cipher_byte_t wdata,
  input  logic [AW-1:0] raddr,
  output cipher_byte_t rdata
);

  cipher_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cipher_out_fifo.sv
// rtl/cipher_out_fifo.sv - show-ahead output FIFO behind the stream cipher with drop accounting
module cipher_out_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_encrypt,
  input  logic                   in_valid,
  input  logic                   flush,
  output logic [7:0]             m_data,
  output logic                   m_encrypt,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr, level_nxt;
  logic          pop, push, drop;
  cipher_byte_t  wr_entry, head;

  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;

  assign wr_entry.encrypt = in_encrypt;
  assign wr_entry.data    = in_data;

  cipher_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push && !flush && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign m_data    = m_valid ? head.data : 8'h00;
  assign m_encrypt = m_valid ? head.encrypt : 1'b0;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + PW'(1);
    else if (pop && !push) level_nxt = level - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cipher_out_fifo.sv
// tb/tb_cipher_out_fifo.sv - scoreboard bench for cipher_out_fifo
module tb_cipher_out_fifo;
  import cipher_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_encrypt, m_ready;
  logic [7:0] in_data;

  logic [7:0] m_data, s_m_data;
  logic       m_encrypt, m_valid, full, overflow;
  logic       s_m_encrypt, s_m_valid, s_full, s_overflow;
  logic [4:0] level, s_level;
  logic [7:0] drop_count;
  logic [1:0] s_drop_count;

  int checks = 0;
  int failures = 0;

  cipher_byte_t exp_q[$];
  int mlevel = 0, mdrop = 0, mdrop_s = 0;
  bit movf = 0;

  always #5 clk = ~clk;

  cipher_out_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_encrypt(in_encrypt),
    .in_valid(in_valid), .flush(flush), .m_data(m_data), .m_encrypt(m_encrypt),
    .m_valid(m_valid), .m_ready(m_ready), .level(level), .full(full),
    .overflow(overflow), .drop_count(drop_count)
  );

  cipher_out_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_encrypt(in_encrypt),
    .in_valid(in_valid), .flush(flush), .m_data(s_m_data), .m_encrypt(s_m_encrypt),
    .m_valid(s_m_valid), .m_ready(m_ready), .level(s_level), .full(s_full),
    .overflow(s_overflow), .drop_count(s_drop_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every handshake the DUT presents must match the scoreboard head.
  initial begin
    cipher_byte_t e;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=%0h expected=none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", m_data, e.data);
          chk("pop_encrypt", m_encrypt, e.encrypt);
        end
      end
    end
  end

  task automatic check_status();
    chk("level", level, mlevel);
    chk("full", full, mlevel == DEPTH);
    chk("m_valid", m_valid, mlevel != 0);
    chk("overflow", overflow, movf);
    chk("drop_count", drop_count, mdrop);
    chk("sat_drop_count", s_drop_count, mdrop_s);
    if (mlevel == 0) begin
      chk("empty_data", m_data, 0);
      chk("empty_encrypt", m_encrypt, 0);
    end
  endtask

  task automatic cycle(input logic v, input logic e, input logic [7:0] d,
                       input logic r, input logic f, input logic rs);
    bit p_pop, p_push, p_drop;
    in_valid = v; in_encrypt = e; in_data = d; m_ready = r; flush = f; rst = rs;
    p_pop  = (mlevel != 0) && r;
    p_push = v && (mlevel < DEPTH || p_pop);
    p_drop = v && (mlevel == DEPTH) && !p_pop;
    @(posedge clk);
    if (rs || f) begin
      exp_q.delete();
      mlevel = 0; movf = 0; mdrop = 0; mdrop_s = 0;
    end else begin
      if (p_push) exp_q.push_back('{encrypt: e, data: d});
      mlevel = mlevel + int'(p_push) - int'(p_pop);
      if (p_drop) begin
        movf = 1;
        if (mdrop < 255) mdrop++;
        if (mdrop_s < 3) mdrop_s++;
      end
    end
    #1;
    check_status();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0;
    in_data = 8'h00; m_ready = 1'b0;

    cycle(0, 0, 8'h00, 0, 0, 1);
    cycle(0, 0, 8'h00, 0, 0, 1);
    cycle(0, 0, 8'h00, 0, 0, 0);

    cycle(1, 1, 8'hA5, 1, 0, 0);
    chk("pass_data", m_data, 8'hA5);
    chk("pass_encrypt", m_encrypt, 1);
    cycle(0, 0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 16; i++) cycle(1, 1'(i), 8'(i), 0, 0, 0);
    cycle(1, 0, 8'h55, 0, 0, 0);
    cycle(1, 1, 8'h66, 0, 0, 0);
    cycle(1, 0, 8'h77, 0, 0, 0);
    chk("ovf_drop3", drop_count, 3);
    cycle(1, 1, 8'h88, 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 16; i++) cycle(1, 1'(i >> 1), 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'(8'hE0 + i), 0, 0, 0);
    chk("sat_value", s_drop_count, 3);
    for (int i = 0; i < 40; i++) cycle(1, 1'(i >> 1), 8'(8'h40 + i), 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h60 + i), 0, 0, 0);
    cycle(1, 0, 8'h99, 1, 1, 0);
    chk("flush_level", level, 0);

    for (int i = 0; i < 16; i++) cycle(1, 1'(i), 8'(8'h70 + i), 0, 0, 0);
    cycle(1, 1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 8'h00, 1, 0, 0);
    cycle(1, 0, 8'h99, 1, 0, 1);
    chk("rst_overflow", overflow, 0);

    cycle(1, 1, 8'h12, 1, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
